// File: rtl/sink_dma_16_if.sv
// Bus bundle for the frame-buffer read DMA: bank read port plus the outgoing byte stream.
// Stream handshake: a byte moves on every rising edge where data_valid && data_ready; once
// data_valid is raised, data_out and data_valid hold until that transfer happens.
interface sink_dma_16_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int SEL_W  = 4
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_address;
  logic [SEL_W-1:0]  ram_select;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output ram_rd_en, ram_address, ram_select, data_out, data_valid,
    input  ram_data, data_ready
  );

  modport slave (
    input  ram_rd_en, ram_address, ram_select, data_out, data_valid,
    output ram_data, data_ready
  );
endinterface

// File: rtl/sink_dma_16.sv
// Read-side DMA: sweeps every bank/address of the frame buffer and streams the bytes out
// through a 2-entry FIFO, issuing reads only when the returned byte is guaranteed a slot.
module sink_dma_16 #(
  parameter int DEPTH   = 940,
  parameter int NUM_RAM = 16,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int SEL_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg,
  sink_dma_16_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_RAM - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic              inflight;
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              pop, push, rd_en, last_rd, empty_next;
  logic [1:0]        occ_next;

  assign pop  = (count != 2'd0) && bus.data_ready;
  assign push = inflight;

  // Occupancy after this cycle's pop; counting the pop keeps 1 byte/cycle with ready high
  // while still bounding buffered + in-flight bytes to the two FIFO slots.
  assign occ_next   = count + {1'b0, inflight} - {1'b0, pop};
  assign rd_en      = (state == READ) && (occ_next < 2'd2);
  assign last_rd    = rd_en && (sel == LAST_SEL) && (addr == LAST_ADDR);
  assign empty_next = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        busy = 1'b1;
        if (last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (empty_next) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final read wraps both counters back to bank 0, address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      sel  <= '0;
    end else if (rd_en) begin
      if (addr == LAST_ADDR) begin
        addr <= '0;
        sel  <= (sel == LAST_SEL) ? '0 : sel + SEL_W'(1);
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= rd_en;
      if (push) begin
        mem[wr_ptr] <= bus.ram_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_address = addr;
  assign bus.ram_select  = sel;
  assign bus.data_out    = mem[rd_ptr];
  assign bus.data_valid  = (count != 2'd0);
  assign state_dbg       = state;

endmodule

// File: tb/tb_sink_dma_16.sv
// Bench for sink_dma_16: RAM model returning {sel[3:0],addr[3:0]}, frame-level scoreboard,
// boundary-byte table, backpressure, ignored starts and mid-frame reset.
module tb_sink_dma_16;
  localparam int DEPTH   = 940;
  localparam int NUM_RAM = 16;
  localparam int FRAME   = DEPTH * NUM_RAM;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done;
  logic [1:0] state_dbg;

  sink_dma_16_if dif ();

  sink_dma_16 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (dif)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk)
    if (dif.ram_rd_en) dif.ram_data <= {dif.ram_select[3:0], dif.ram_address[3:0]};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int s, a;
    s = k / DEPTH;
    a = k % DEPTH;
    return {s[3:0], a[3:0]};
  endfunction

  // scoreboard / reference model
  typedef enum {M_IDLE, M_ACTIVE, M_DONE} mphase_t;
  mphase_t    mph = M_IDLE;
  logic [7:0] exp_q[$];
  int         rd_idx = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] cap [FRAME];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (!rst) begin
      mph = M_IDLE;
      exp_q.delete();
      rd_idx    = 0;
      xfer_cnt  = 0;
      hold_pend = 1'b0;
    end else begin
      chk("busy", busy, mph == M_ACTIVE);
      chk("done", done, mph == M_DONE);
      if (done) done_cnt++;
      if (hold_pend) begin
        chk("hold_valid", dif.data_valid, 1);
        chk("hold_data", dif.data_out, hold_data);
      end
      if (dif.ram_rd_en) begin
        chk("rd_in_frame", (mph == M_ACTIVE) && (rd_idx < FRAME), 1);
        chk("rd_sel", dif.ram_select, rd_idx / DEPTH);
        chk("rd_addr", dif.ram_address, rd_idx % DEPTH);
        rd_idx++;
      end
      hold_pend = dif.data_valid && !dif.data_ready;
      hold_data = dif.data_out;
      if (dif.data_valid && dif.data_ready) begin
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("byte", dif.data_out, exp_q.pop_front());
        if (xfer_cnt < FRAME) cap[xfer_cnt] = dif.data_out;
        xfer_cnt++;
      end
      chk("occupancy", (rd_idx - xfer_cnt) <= 2, 1);
      case (mph)
        M_IDLE: if (start) begin
          mph = M_ACTIVE;
          exp_q.delete();
          for (int k = 0; k < FRAME; k++) exp_q.push_back(exp_byte(k));
          rd_idx   = 0;
          xfer_cnt = 0;
        end
        M_ACTIVE: if (xfer_cnt == FRAME) mph = M_DONE;
        default:  mph = M_IDLE;
      endcase
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [10];

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, dif.ram_rd_en, 0);
    chk({tag, "_addr"}, dif.ram_address, 0);
    chk({tag, "_sel"}, dif.ram_select, 0);
    chk({tag, "_data_out"}, dif.data_out, 0);
    chk({tag, "_valid"}, dif.data_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int d0, gaps, stall_left;
    logic stalled, drain_req, drain_hit;

    vt[0] = '{idx: 0,     exp: 8'h00};
    vt[1] = '{idx: 100,   exp: 8'h04};
    vt[2] = '{idx: 939,   exp: 8'h0B};
    vt[3] = '{idx: 940,   exp: 8'h10};
    vt[4] = '{idx: 941,   exp: 8'h11};
    vt[5] = '{idx: 1879,  exp: 8'h1B};
    vt[6] = '{idx: 1880,  exp: 8'h20};
    vt[7] = '{idx: 5000,  exp: 8'h5C};
    vt[8] = '{idx: 14100, exp: 8'hF0};
    vt[9] = '{idx: 15039, exp: 8'hFB};

    rst = 1'b0;
    start = 1'b0;
    dif.data_ready = 1'b0;
    #1;
    check_outputs_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // frame A: ready high, 5-cycle stall, starts pulsed in READ and DRAIN
    dif.data_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("lat_rd_en", dif.ram_rd_en, 1);
    @(negedge clk);
    chk("lat_valid_early", dif.data_valid, 0);
    @(negedge clk);
    chk("lat_valid", dif.data_valid, 1);
    chk("lat_first_byte", dif.data_out, 8'h00);

    d0 = done_cnt; gaps = 0; stall_left = 0;
    stalled = 1'b0; drain_req = 1'b0; drain_hit = 1'b0;
    for (int c = 0; c < 20000 && done_cnt == d0; c++) begin
      @(posedge clk);
      #1;
      start = (c == 200) || (drain_req && !drain_hit);
      if (drain_req) drain_hit = 1'b1;
      if (!stalled && xfer_cnt >= 3000) begin
        stalled = 1'b1;
        stall_left = 5;
        dif.data_ready = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) dif.data_ready = 1'b1;
      end
      @(negedge clk);
      if (!dif.data_ready && stall_left <= 4) chk("stall_rd_en", dif.ram_rd_en, 0);
      if (state_dbg == ST_DRAIN) drain_req = 1'b1;
      if (!dif.data_valid && xfer_cnt < FRAME) gaps++;
    end
    start = 1'b0;
    chk("a_done_once", done_cnt - d0, 1);
    chk("a_bytes", xfer_cnt, FRAME);
    chk("a_valid_gaps", gaps, 0);
    chk("a_stall_applied", stalled, 1);
    chk("a_drain_start_sent", drain_hit, 1);
    repeat (4) @(negedge clk);
    chk("a_idle_after", busy, 0);
    chk("a_single_done", done_cnt - d0, 1);
    for (int i = 0; i < 10; i++) chk($sformatf("tbl_byte_%0d", vt[i].idx), cap[vt[i].idx], vt[i].exp);

    // frame B: ready toggled every cycle
    @(posedge clk);
    #1;
    d0 = done_cnt;
    dif.data_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 40000 && done_cnt == d0; c++) begin
      @(posedge clk);
      #1 dif.data_ready = ~dif.data_ready;
    end
    chk("b_done_once", done_cnt - d0, 1);
    chk("b_bytes", xfer_cnt, FRAME);
    chk("b_last_byte", cap[FRAME-1], 8'hFB);
    chk("b_bank_edge", cap[940], 8'h10);

    // frame C: reset at byte 5000, then restart from bank 0
    dif.data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 10000 && xfer_cnt < 5000; c++) @(posedge clk);
    chk("c_reached_5000", xfer_cnt >= 5000, 1);
    #3 rst = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    chk("mid_rst_state", state_dbg, 2'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 200 && xfer_cnt < 16; c++) @(posedge clk);
    #1;
    chk("c_restart_bytes", xfer_cnt >= 16, 1);
    chk("c_first_byte", cap[0], 8'h00);
    chk("c_byte15", cap[15], 8'h0F);
    chk("c_no_done", done_cnt - d0, 0);
    chk("c_busy", busy, 1);

    rst = 1'b0;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
